isr_priority_unit: RTL and testbench

- Parametrised, clocked successor to the 8259A-style in-service register: holds the ISR vector and resolves priority among NUM_IRQ request levels.
- Runs the two-pulse INTA acknowledge sequence and executes OCW2-style EOI and rotation commands.
- Drives the interrupt request to the CPU.
- Sits between the IRR/mask logic (consumes masked requests) and the control logic/cascade block (supplies acknowledged level and INT).

---
 rtl/isr_priority_unit.sv | 182 ++++++++++++++++++
 tb/tb_isr_priority_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/isr_priority_unit.sv
// ==========================================================================
// isr_priority_unit: in-service register, rotating priority resolver, INTA
// acknowledge sequencer and OCW2-style EOI/rotation handling. Rev 1.0
// ==========================================================================
`default_nettype none

module isr_priority_unit #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irr,
  input  logic               inta_pulse,
  input  logic               aeoi_en,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [IDX_W-1:0]   cmd_level,
  output logic [NUM_IRQ-1:0] isr,
  output logic               int_req,
  output logic [IDX_W-1:0]   ack_level,
  output logic               ack_spurious,
  output logic [NUM_IRQ-1:0] irr_clear,
  output logic [IDX_W-1:0]   lowest_prio,
  output logic               rotate_aeoi,
  output logic               inta_busy
);

  localparam logic [0:0]       S_IDLE  = 1'b0;
  localparam logic [0:0]       S_ACK1  = 1'b1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_IRQ - 1);

  localparam logic [2:0] OP_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OP_NS_EOI       = 3'b001;
  localparam logic [2:0] OP_NOP          = 3'b010;
  localparam logic [2:0] OP_S_EOI        = 3'b011;
  localparam logic [2:0] OP_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OP_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OP_SET_PRIO     = 3'b110;
  localparam logic [2:0] OP_ROT_S_EOI    = 3'b111;

  // Rank 0 is the level just above lowest_prio, i.e. the highest priority.
  function automatic logic [IDX_W-1:0] rank_of(input logic [IDX_W-1:0] lvl,
                                               input logic [IDX_W-1:0] lp);
    return lvl - lp - IDX_ONE;
  endfunction

  function automatic logic [IDX_W-1:0] top_of(input logic [NUM_IRQ-1:0] vec,
                                              input logic [IDX_W-1:0]   lp);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] top;
    top = '0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      idx = lp + IDX_ONE + IDX_W'(r);
      if (vec[idx]) top = idx;
    end
    return top;
  endfunction

  function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] lvl);
    return NUM_IRQ'(1) << lvl;
  endfunction

  logic [0:0]         state;
  logic [0:0]         state_d;
  logic [IDX_W-1:0]   top_irr;
  logic [IDX_W-1:0]   top_isr;
  logic               irr_any;
  logic               isr_any;
  logic               nested_ok;
  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [NUM_IRQ-1:0] isr_d;
  logic [NUM_IRQ-1:0] irr_clear_d;
  logic [IDX_W-1:0]   lowest_prio_d;
  logic [IDX_W-1:0]   ack_level_d;
  logic               ack_spurious_d;
  logic               rotate_aeoi_d;
  logic               int_req_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (inta_pulse) state_d = S_ACK1;
      S_ACK1:  if (inta_pulse) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inta_busy = (state == S_ACK1);
  end

  assign top_irr   = top_of(irr, lowest_prio);
  assign top_isr   = top_of(isr, lowest_prio);
  assign irr_any   = |irr;
  assign isr_any   = |isr;
  assign nested_ok = !isr_any ||
                     (rank_of(top_irr, lowest_prio) < rank_of(top_isr, lowest_prio));

  always_comb begin
    set_mask       = '0;
    clr_mask       = '0;
    irr_clear_d    = '0;
    lowest_prio_d  = lowest_prio;
    rotate_aeoi_d  = rotate_aeoi;
    ack_level_d    = ack_level;
    ack_spurious_d = ack_spurious;

    if ((state == S_IDLE) && inta_pulse) begin
      if (irr_any) begin
        set_mask       = onehot(top_irr);
        irr_clear_d    = onehot(top_irr);
        ack_level_d    = top_irr;
        ack_spurious_d = 1'b0;
      end else begin
        ack_level_d    = IDX_MAX;
        ack_spurious_d = 1'b1;
      end
    end

    if ((state == S_ACK1) && inta_pulse && aeoi_en && !ack_spurious) begin
      clr_mask = onehot(ack_level);
      if (rotate_aeoi) lowest_prio_d = ack_level;
    end

    // Evaluated after the AEOI path so a command's lowest_prio write wins.
    if (cmd_valid) begin
      case (cmd_op)
        OP_NS_EOI:       if (isr_any) clr_mask = clr_mask | onehot(top_isr);
        OP_S_EOI:        clr_mask = clr_mask | onehot(cmd_level);
        OP_ROT_NS_EOI: begin
          if (isr_any) begin
            clr_mask      = clr_mask | onehot(top_isr);
            lowest_prio_d = top_isr;
          end
        end
        OP_ROT_S_EOI: begin
          clr_mask      = clr_mask | onehot(cmd_level);
          lowest_prio_d = cmd_level;
        end
        OP_SET_PRIO:     lowest_prio_d = cmd_level;
        OP_ROT_AEOI_SET: rotate_aeoi_d = 1'b1;
        OP_ROT_AEOI_CLR: rotate_aeoi_d = 1'b0;
        OP_NOP:          ;
        default:         ;
      endcase
    end

    isr_d     = (isr & ~clr_mask) | set_mask;
    int_req_d = (state_d == S_IDLE) && irr_any && nested_ok;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      isr          <= '0;
      int_req      <= 1'b0;
      ack_level    <= IDX_MAX;
      ack_spurious <= 1'b0;
      irr_clear    <= '0;
      lowest_prio  <= IDX_MAX;
      rotate_aeoi  <= 1'b0;
    end else begin
      isr          <= isr_d;
      int_req      <= int_req_d;
      ack_level    <= ack_level_d;
      ack_spurious <= ack_spurious_d;
      irr_clear    <= irr_clear_d;
      lowest_prio  <= lowest_prio_d;
      rotate_aeoi  <= rotate_aeoi_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_isr_priority_unit.sv
// ==========================================================================
// tb_isr_priority_unit: directed scoreboard bench for isr_priority_unit. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_isr_priority_unit;

  logic       clk;
  logic       reset_n;
  logic [7:0] irr;
  logic       inta_pulse;
  logic       aeoi_en;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [2:0] cmd_level;
  logic [7:0] isr;
  logic       int_req;
  logic [2:0] ack_level;
  logic       ack_spurious;
  logic [7:0] irr_clear;
  logic [2:0] lowest_prio;
  logic       rotate_aeoi;
  logic       inta_busy;

  int checks   = 0;
  int failures = 0;

  isr_priority_unit #(.NUM_IRQ(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .irr          (irr),
    .inta_pulse   (inta_pulse),
    .aeoi_en      (aeoi_en),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_level    (cmd_level),
    .isr          (isr),
    .int_req      (int_req),
    .ack_level    (ack_level),
    .ack_spurious (ack_spurious),
    .irr_clear    (irr_clear),
    .lowest_prio  (lowest_prio),
    .rotate_aeoi  (rotate_aeoi),
    .inta_busy    (inta_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] isr;
    logic       ir;
    logic [2:0] al;
    logic       sp;
    logic [7:0] ic;
    logic [2:0] lp;
    logic       rot;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  task automatic exp_push(input string n, input logic [7:0] e_isr, input logic e_ir,
                          input logic [2:0] e_al, input logic e_sp, input logic [7:0] e_ic,
                          input logic [2:0] e_lp, input logic e_rot, input logic e_busy);
    exp_t e;
    e.name = n; e.isr = e_isr; e.ir = e_ir; e.al = e_al; e.sp = e_sp;
    e.ic = e_ic; e.lp = e_lp; e.rot = e_rot; e.busy = e_busy;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  // Monitor: registered outputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".isr"},          32'(isr),          32'(e.isr));
      chk({e.name, ".int_req"},      32'(int_req),      32'(e.ir));
      chk({e.name, ".ack_level"},    32'(ack_level),    32'(e.al));
      chk({e.name, ".ack_spurious"}, 32'(ack_spurious), 32'(e.sp));
      chk({e.name, ".irr_clear"},    32'(irr_clear),    32'(e.ic));
      chk({e.name, ".lowest_prio"},  32'(lowest_prio),  32'(e.lp));
      chk({e.name, ".rotate_aeoi"},  32'(rotate_aeoi),  32'(e.rot));
      chk({e.name, ".inta_busy"},    32'(inta_busy),    32'(e.busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    inta_pulse = 1'b0;
    cmd_valid  = 1'b0;
  endtask

  task automatic inta();
    inta_pulse = 1'b1;
    tick();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [2:0] lvl);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_level = lvl;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; irr = 8'h00; inta_pulse = 1'b0; aeoi_en = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'b000; cmd_level = 3'd0;
    tick(); tick();
    exp_push("reset", 8'h00, 0, 3'd7, 0, 8'h00, 3'd7, 0, 0);
    reset_n = 1'b1;

    // Acknowledge, hold without AEOI, non-specific EOI re-raises INT
    irr = 8'h06; tick();
    exp_push("t1_req", 8'h00, 1, 3'd7, 0, 8'h00, 3'd7, 0, 0);
    inta();
    exp_push("t1_ack1", 8'h02, 0, 3'd1, 0, 8'h02, 3'd7, 0, 1);
    irr = 8'h04; tick();
    exp_push("t1_wait", 8'h02, 0, 3'd1, 0, 8'h00, 3'd7, 0, 1);
    inta();
    exp_push("t1_ack2", 8'h02, 0, 3'd1, 0, 8'h00, 3'd7, 0, 0);
    cmd(3'b001, 3'd0);
    exp_push("t1_eoi", 8'h00, 0, 3'd1, 0, 8'h00, 3'd7, 0, 0);
    tick();
    exp_push("t1_rereq", 8'h00, 1, 3'd1, 0, 8'h00, 3'd7, 0, 0);

    // Fully nested blocking: lower and equal rank never request
    irr = 8'h10; inta();
    exp_push("t2_ack1", 8'h10, 0, 3'd4, 0, 8'h10, 3'd7, 0, 1);
    irr = 8'h20; inta();
    exp_push("t2_ack2", 8'h10, 0, 3'd4, 0, 8'h00, 3'd7, 0, 0);
    tick();
    exp_push("t2_lower", 8'h10, 0, 3'd4, 0, 8'h00, 3'd7, 0, 0);
    irr = 8'h10; tick();
    exp_push("t2_equal", 8'h10, 0, 3'd4, 0, 8'h00, 3'd7, 0, 0);
    irr = 8'h08; tick();
    exp_push("t2_higher", 8'h10, 1, 3'd4, 0, 8'h00, 3'd7, 0, 0);

    // Set priority, then rotated resolution
    irr = 8'h00; cmd(3'b011, 3'd4);
    exp_push("t3_seoi", 8'h00, 0, 3'd4, 0, 8'h00, 3'd7, 0, 0);
    cmd(3'b110, 3'd3);
    exp_push("t3_setpri", 8'h00, 0, 3'd4, 0, 8'h00, 3'd3, 0, 0);
    irr = 8'h21; tick();
    exp_push("t3_req", 8'h00, 1, 3'd4, 0, 8'h00, 3'd3, 0, 0);
    inta();
    exp_push("t3_ack1", 8'h20, 0, 3'd5, 0, 8'h20, 3'd3, 0, 1);
    irr = 8'h01; inta();
    exp_push("t3_ack2", 8'h20, 0, 3'd5, 0, 8'h00, 3'd3, 0, 0);
    irr = 8'h00; cmd(3'b001, 3'd0);
    exp_push("t3_eoi", 8'h00, 0, 3'd5, 0, 8'h00, 3'd3, 0, 0);
    cmd(3'b110, 3'd7);
    exp_push("t3_restore", 8'h00, 0, 3'd5, 0, 8'h00, 3'd7, 0, 0);

    // AEOI with and without rotation
    aeoi_en = 1'b1; cmd(3'b100, 3'd0);
    exp_push("t4_rot_on", 8'h00, 0, 3'd5, 0, 8'h00, 3'd7, 1, 0);
    irr = 8'h08; inta();
    exp_push("t4_ack1", 8'h08, 0, 3'd3, 0, 8'h08, 3'd7, 1, 1);
    irr = 8'h00; inta();
    exp_push("t4_aeoi", 8'h00, 0, 3'd3, 0, 8'h00, 3'd3, 1, 0);
    cmd(3'b110, 3'd7);
    exp_push("t4_restore", 8'h00, 0, 3'd3, 0, 8'h00, 3'd7, 1, 0);
    cmd(3'b000, 3'd0);
    exp_push("t4_rot_off", 8'h00, 0, 3'd3, 0, 8'h00, 3'd7, 0, 0);
    irr = 8'h08; inta();
    exp_push("t4b_ack1", 8'h08, 0, 3'd3, 0, 8'h08, 3'd7, 0, 1);
    irr = 8'h00; inta();
    exp_push("t4b_aeoi", 8'h00, 0, 3'd3, 0, 8'h00, 3'd7, 0, 0);
    aeoi_en = 1'b0;

    // Build isr=0C, then rotating EOIs and an empty non-specific rotate
    irr = 8'h08; inta();
    exp_push("t5_ack_a", 8'h08, 0, 3'd3, 0, 8'h08, 3'd7, 0, 1);
    irr = 8'h00; inta();
    exp_push("t5_ack_a2", 8'h08, 0, 3'd3, 0, 8'h00, 3'd7, 0, 0);
    irr = 8'h04; tick();
    exp_push("t5_req", 8'h08, 1, 3'd3, 0, 8'h00, 3'd7, 0, 0);
    inta();
    exp_push("t5_ack_b", 8'h0C, 0, 3'd2, 0, 8'h04, 3'd7, 0, 1);
    irr = 8'h00; inta();
    exp_push("t5_ack_b2", 8'h0C, 0, 3'd2, 0, 8'h00, 3'd7, 0, 0);
    cmd(3'b101, 3'd0);
    exp_push("t5_rot_ns", 8'h08, 0, 3'd2, 0, 8'h00, 3'd2, 0, 0);
    cmd(3'b111, 3'd3);
    exp_push("t5_rot_s", 8'h00, 0, 3'd2, 0, 8'h00, 3'd3, 0, 0);
    cmd(3'b101, 3'd0);
    exp_push("t5_ns_empty", 8'h00, 0, 3'd2, 0, 8'h00, 3'd3, 0, 0);

    // Spurious acknowledge, then reset in the middle of the sequence
    inta();
    exp_push("t6_spur", 8'h00, 0, 3'd7, 1, 8'h00, 3'd3, 0, 1);
    reset_n = 1'b0; tick();
    exp_push("t6_reset", 8'h00, 0, 3'd7, 0, 8'h00, 3'd7, 0, 0);
    reset_n = 1'b1;

    tick(); tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
